// File: rtl/huffman_encoder.sv
// JPEG luminance Huffman encoder: one symbol per handshake, codeword then amplitude bits MSB-first, first bit 2 cycles after accept.
// ready_in=0 freezes the bit stream; HUFFMAN_ENC_BLOCK_CHECK_EN adds a sticky block_err_out coefficient-count checker.
module huffman_encoder #(
    parameter int CODE_W  = 16,
    parameter int VALUE_W = 11
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               valid_in,
    output logic               ready_out,
    input  logic               dc_in,
    input  logic               eob_in,
    input  logic [4:0]         run_in,
    input  logic [4:0]         size_in,
    input  logic [VALUE_W-1:0] value_in,
    output logic               serial_out,
    output logic               valid_out,
    input  logic               ready_in,
`ifdef HUFFMAN_ENC_BLOCK_CHECK_EN
    output logic               block_err_out,
`endif
    output logic               idle_out
);

    localparam int IDX_W = $clog2(CODE_W);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_CODE, S_VALUE} state_t;

    // ROM word layout: {code_len[4:0], code[15:0]}, code right-aligned.
    function automatic logic [20:0] huffman_dc_code_rom(input logic [3:0] addr);
        logic [20:0] r;
        case (addr)
            4'd0:    r = {5'd2, 16'd0};
            4'd1:    r = {5'd3, 16'd2};
            4'd2:    r = {5'd3, 16'd3};
            4'd3:    r = {5'd3, 16'd4};
            4'd4:    r = {5'd3, 16'd5};
            4'd5:    r = {5'd3, 16'd6};
            4'd6:    r = {5'd4, 16'd14};
            4'd7:    r = {5'd5, 16'd30};
            4'd8:    r = {5'd6, 16'd62};
            4'd9:    r = {5'd7, 16'd126};
            4'd10:   r = {5'd8, 16'd254};
            4'd11:   r = {5'd9, 16'd510};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [20:0] huffman_ac_code_rom(input logic [7:0] addr);
        logic [20:0] r;
        logic [7:0]  base;
        logic [7:0]  first;
        // Every 16-bit code is consecutive from 0xFF82 in (run,size) order,
        // so a per-run base offset and first long size replace 125 entries.
        case (addr[7:4])
            4'h0:    begin base = 8'd0;   first = 8'd9; end
            4'h1:    begin base = 8'd2;   first = 8'd6; end
            4'h2:    begin base = 8'd7;   first = 8'd5; end
            4'h3:    begin base = 8'd13;  first = 8'd4; end
            4'h4:    begin base = 8'd20;  first = 8'd3; end
            4'h5:    begin base = 8'd28;  first = 8'd3; end
            4'h6:    begin base = 8'd36;  first = 8'd3; end
            4'h7:    begin base = 8'd44;  first = 8'd3; end
            4'h8:    begin base = 8'd52;  first = 8'd3; end
            4'h9:    begin base = 8'd60;  first = 8'd2; end
            4'ha:    begin base = 8'd69;  first = 8'd2; end
            4'hb:    begin base = 8'd78;  first = 8'd2; end
            4'hc:    begin base = 8'd87;  first = 8'd2; end
            4'hd:    begin base = 8'd96;  first = 8'd2; end
            4'he:    begin base = 8'd105; first = 8'd1; end
            default: begin base = 8'd115; first = 8'd1; end
        endcase
        case (addr)
            8'h01: r = {5'd2, 16'd0};     8'h02: r = {5'd2, 16'd1};
            8'h03: r = {5'd3, 16'd4};
            8'h00: r = {5'd4, 16'd10};    8'h04: r = {5'd4, 16'd11};
            8'h11: r = {5'd4, 16'd12};
            8'h05: r = {5'd5, 16'd26};    8'h12: r = {5'd5, 16'd27};
            8'h21: r = {5'd5, 16'd28};
            8'h31: r = {5'd6, 16'd58};    8'h41: r = {5'd6, 16'd59};
            8'h06: r = {5'd7, 16'd120};   8'h13: r = {5'd7, 16'd121};
            8'h51: r = {5'd7, 16'd122};   8'h61: r = {5'd7, 16'd123};
            8'h07: r = {5'd8, 16'd248};   8'h22: r = {5'd8, 16'd249};
            8'h71: r = {5'd8, 16'd250};
            8'h14: r = {5'd9, 16'd502};   8'h32: r = {5'd9, 16'd503};
            8'h81: r = {5'd9, 16'd504};   8'h91: r = {5'd9, 16'd505};
            8'ha1: r = {5'd9, 16'd506};
            8'h08: r = {5'd10, 16'd1014}; 8'h23: r = {5'd10, 16'd1015};
            8'h42: r = {5'd10, 16'd1016}; 8'hb1: r = {5'd10, 16'd1017};
            8'hc1: r = {5'd10, 16'd1018};
            8'h15: r = {5'd11, 16'd2038}; 8'h52: r = {5'd11, 16'd2039};
            8'hd1: r = {5'd11, 16'd2040}; 8'hf0: r = {5'd11, 16'd2041};
            8'h24: r = {5'd12, 16'd4084}; 8'h33: r = {5'd12, 16'd4085};
            8'h62: r = {5'd12, 16'd4086}; 8'h72: r = {5'd12, 16'd4087};
            8'h82: r = {5'd15, 16'd32704};
            default: r = {5'd16, 16'hFF82 + {8'h00, base + {4'h0, addr[3:0]} - first}};
        endcase
        return r;
    endfunction

    state_t              state;
    logic                accept;
    logic                illegal_in;
    logic                illegal_q;
    logic [20:0]         rom_word;
    logic [CODE_W-1:0]   rom_code;
    logic [4:0]          rom_len;
    logic [IDX_W-1:0]    rom_top;
    logic [CODE_W-1:0]   code_q;
    logic [4:0]          size_q;
    logic [VALUE_W-1:0]  value_q;
    logic [IDX_W-1:0]    bit_idx;
    logic [IDX_W-1:0]    idx_dec;
    logic [IDX_W-1:0]    size_top;

    assign accept   = (state == S_IDLE) && ready_out && valid_in;
    assign idle_out = (state == S_IDLE);
    assign rom_top  = IDX_W'(rom_len - 5'd1);
    assign idx_dec  = bit_idx - 1'b1;
    assign size_top = IDX_W'(size_q - 5'd1);

    always_comb begin
        illegal_in = 1'b0;
        if (dc_in) begin
            illegal_in = (size_in > 5'd11);
        end else if (!eob_in) begin
            illegal_in = run_in[4] || (size_in > 5'd10) ||
                         ((size_in == 5'd0) && (run_in != 5'd0) && (run_in != 5'd15));
        end
    end

    always_comb begin
        rom_word = '0;
        if (dc_in)
            rom_word = huffman_dc_code_rom(size_in[3:0]);
        else if (eob_in)
            rom_word = huffman_ac_code_rom(8'h00);
        else
            rom_word = huffman_ac_code_rom({run_in[3:0], size_in[3:0]});
    end

    // Registered ROM: addressed straight from the inputs while idle so the
    // codeword is ready by the end of S_LOOKUP.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rom_code <= '0;
            rom_len  <= '0;
        end else if (state == S_IDLE) begin
            rom_code <= CODE_W'(rom_word[15:0]);
            rom_len  <= rom_word[20:16];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= S_IDLE;
            ready_out  <= 1'b0;
            serial_out <= 1'b0;
            valid_out  <= 1'b0;
            illegal_q  <= 1'b0;
            code_q     <= '0;
            size_q     <= '0;
            value_q    <= '0;
            bit_idx    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    ready_out <= 1'b1;
                    if (accept) begin
                        ready_out <= 1'b0;
                        illegal_q <= illegal_in;
                        size_q    <= (eob_in && !dc_in) ? 5'd0 : size_in;
                        value_q   <= value_in;
                        state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (illegal_q) begin
                        ready_out <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        code_q     <= rom_code;
                        bit_idx    <= rom_top;
                        serial_out <= rom_code[rom_top];
                        valid_out  <= 1'b1;
                        state      <= S_CODE;
                    end
                end
                S_CODE: begin
                    if (ready_in) begin
                        if (bit_idx != '0) begin
                            bit_idx    <= idx_dec;
                            serial_out <= code_q[idx_dec];
                        end else if (size_q != 5'd0) begin
                            bit_idx    <= size_top;
                            serial_out <= value_q[size_top];
                            state      <= S_VALUE;
                        end else begin
                            serial_out <= 1'b0;
                            valid_out  <= 1'b0;
                            ready_out  <= 1'b1;
                            state      <= S_IDLE;
                        end
                    end
                end
                S_VALUE: begin
                    if (ready_in) begin
                        if (bit_idx != '0) begin
                            bit_idx    <= idx_dec;
                            serial_out <= value_q[idx_dec];
                        end else begin
                            serial_out <= 1'b0;
                            valid_out  <= 1'b0;
                            ready_out  <= 1'b1;
                            state      <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef HUFFMAN_ENC_BLOCK_CHECK_EN
    logic [6:0] coef_cnt;
    logic       expect_dc;
    logic [7:0] cnt_sum;

    assign cnt_sum = {1'b0, coef_cnt} + {3'b000, run_in} + 8'd1;

    // Counts coefficient positions per 8x8 block; expect_dc marks a closed block.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            coef_cnt      <= '0;
            expect_dc     <= 1'b0;
            block_err_out <= 1'b0;
        end else if (accept) begin
            if (dc_in) begin
                if (!expect_dc && (coef_cnt != 7'd0) && (coef_cnt < 7'd64))
                    block_err_out <= 1'b1;
                coef_cnt  <= 7'd1;
                expect_dc <= 1'b0;
            end else if (eob_in) begin
                expect_dc <= 1'b1;
            end else begin
                if (expect_dc || (cnt_sum > 8'd64))
                    block_err_out <= 1'b1;
                coef_cnt <= (cnt_sum > 8'd127) ? 7'd127 : cnt_sum[6:0];
                if (cnt_sum >= 8'd64)
                    expect_dc <= 1'b1;
            end
        end
    end
`endif

endmodule
